// File: rtl/dispatch_buffer.sv
// Dispatch buffer: a small in-order circular queue between ID/EX and rename/RS.
// Accepts decoded instructions while not full and presents the oldest entry
// at its outputs. Drops are counted when full, and flush discards all entries.
module dispatch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    input  logic [6:0]                 opcode_in,
    input  logic [2:0]                 funct3_in,
    input  logic [6:0]                 funct7_in,
    input  logic [4:0]                 srcReg1_in,
    input  logic [4:0]                 srcReg2_in,
    input  logic [4:0]                 destReg_in,
    input  logic [31:0]                imm_in,
    input  logic [1:0]                 lwSw_in,
    input  logic [31:0]                PC_in,
    input  logic                       regWrite_in,
    input  logic                       memRead_in,
    input  logic                       memWrite_in,
    input  logic                       memToReg_in,
    input  logic                       hasImm_in,
    output logic                       stall,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [6:0]                 opcode_out,
    output logic [2:0]                 funct3_out,
    output logic [6:0]                 funct7_out,
    output logic [4:0]                 srcReg1_out,
    output logic [4:0]                 srcReg2_out,
    output logic [4:0]                 destReg_out,
    output logic [31:0]                imm_out,
    output logic [1:0]                 lwSw_out,
    output logic [31:0]                PC_out,
    output logic                       regWrite_out,
    output logic                       memRead_out,
    output logic                       memWrite_out,
    output logic                       memToReg_out,
    output logic                       hasImm_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [1:0]  lwsw;
        logic [31:0] pc;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        has_imm;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      drop_q, drop_d;

    logic   full, empty, req, push, pop, drop;
    entry_t in_e, head_e;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    assign in_e = '{opcode: opcode_in, funct3: funct3_in, funct7: funct7_in,
                    src1: srcReg1_in, src2: srcReg2_in, dest: destReg_in,
                    imm: imm_in, lwsw: lwSw_in, pc: PC_in,
                    reg_write: regWrite_in, mem_read: memRead_in,
                    mem_write: memWrite_in, mem_to_reg: memToReg_in,
                    has_imm: hasImm_in};

    // Handshake decode and next-state pointers/occupancy; full refuses a push
    // even when the head is leaving in the same cycle.
    always_comb begin
        req     = disp_valid && (opcode_in != 7'd0) && !flush;
        push    = req && !full;
        drop    = req && full;
        pop     = !empty && issue_ready && !flush;
        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        drop_d  = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    // State update: reset clears everything, flush empties the queue but keeps drop_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            drop_q <= drop_d;
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                head_q  <= head_d;
                tail_q  <= tail_d;
                count_q <= count_d;
                if (push) mem_q[tail_q] <= in_e;
            end
        end
    end

    // Head entry presented combinationally; zeroed when nothing is buffered.
    always_comb begin
        head_e = empty ? '0 : mem_q[head_q];
    end

    assign stall        = full;
    assign issue_valid  = !empty;
    assign count        = count_q;
    assign drop_cnt     = drop_q;
    assign opcode_out   = head_e.opcode;
    assign funct3_out   = head_e.funct3;
    assign funct7_out   = head_e.funct7;
    assign srcReg1_out  = head_e.src1;
    assign srcReg2_out  = head_e.src2;
    assign destReg_out  = head_e.dest;
    assign imm_out      = head_e.imm;
    assign lwSw_out     = head_e.lwsw;
    assign PC_out       = head_e.pc;
    assign regWrite_out = head_e.reg_write;
    assign memRead_out  = head_e.mem_read;
    assign memWrite_out = head_e.mem_write;
    assign memToReg_out = head_e.mem_to_reg;
    assign hasImm_out   = head_e.has_imm;

endmodule

// File: tb/tb_dispatch_buffer.sv
// Scoreboard bench for dispatch_buffer: accepted pushes are queued, and each
// entry is compared against the head outputs when the consumer takes it.
module tb_dispatch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 0;
    logic        rst, flush, disp_valid, issue_ready;
    logic [6:0]  opcode_in, funct7_in;
    logic [2:0]  funct3_in;
    logic [4:0]  srcReg1_in, srcReg2_in, destReg_in;
    logic [31:0] imm_in, PC_in;
    logic [1:0]  lwSw_in;
    logic        regWrite_in, memRead_in, memWrite_in, memToReg_in, hasImm_in;
    logic        stall, issue_valid;
    logic [6:0]  opcode_out, funct7_out;
    logic [2:0]  funct3_out;
    logic [4:0]  srcReg1_out, srcReg2_out, destReg_out;
    logic [31:0] imm_out, PC_out;
    logic [1:0]  lwSw_out;
    logic        regWrite_out, memRead_out, memWrite_out, memToReg_out, hasImm_out;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   m_drop;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dispatch_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid),
        .opcode_in(opcode_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
        .srcReg1_in(srcReg1_in), .srcReg2_in(srcReg2_in), .destReg_in(destReg_in),
        .imm_in(imm_in), .lwSw_in(lwSw_in), .PC_in(PC_in),
        .regWrite_in(regWrite_in), .memRead_in(memRead_in), .memWrite_in(memWrite_in),
        .memToReg_in(memToReg_in), .hasImm_in(hasImm_in),
        .stall(stall), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .opcode_out(opcode_out), .funct3_out(funct3_out), .funct7_out(funct7_out),
        .srcReg1_out(srcReg1_out), .srcReg2_out(srcReg2_out), .destReg_out(destReg_out),
        .imm_out(imm_out), .lwSw_out(lwSw_out), .PC_out(PC_out),
        .regWrite_out(regWrite_out), .memRead_out(memRead_out), .memWrite_out(memWrite_out),
        .memToReg_out(memToReg_out), .hasImm_out(hasImm_out),
        .count(count), .drop_cnt(drop_cnt)
    );

    // One clock with the given stimulus; the model tracks what the buffer must hold.
    task automatic drive(input bit dv, input logic [6:0] op, input logic [4:0] rd,
                         input logic [31:0] pc, input bit rdy, input bit fl);
        bit do_push, do_pop, do_drop;
        disp_valid  = dv;
        opcode_in   = op;
        destReg_in  = rd;
        PC_in       = pc;
        imm_in      = pc ^ 32'hA5A5_0F0F;
        issue_ready = rdy;
        flush       = fl;
        do_pop  = (sb.size() != 0) && rdy && !fl;
        do_push = dv && (op != 0) && (sb.size() < DEPTH) && !fl;
        do_drop = dv && (op != 0) && (sb.size() == DEPTH) && !fl;
        @(posedge clk);
        #1;
        if (fl) sb.delete();
        else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back('{op: op, rd: rd, imm: pc ^ 32'hA5A5_0F0F, pc: pc});
        end
        if (do_drop && m_drop < 255) m_drop++;
        disp_valid  = 0;
        issue_ready = 0;
        flush       = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        sb.delete();
        m_drop = 0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (stall !== 1'b0 || issue_valid !== 1'b0) begin errors++; $display("FAIL reset_flags got stall=%b iv=%b want 0 0", stall, issue_valid); end
        checks++; if (opcode_out !== 7'd0 || PC_out !== 32'd0 || imm_out !== 32'd0 || hasImm_out !== 1'b0)
            begin errors++; $display("FAIL reset_fields got op=%h pc=%h imm=%h want zeros", opcode_out, PC_out, imm_out); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_single();
        drive(1, 7'h33, 5'd5, 32'h100, 0, 0);
        checks++; if (issue_valid !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL single_valid got iv=%b cnt=%0d want 1 1", issue_valid, count); end
        checks++; if (opcode_out !== 7'h33 || destReg_out !== 5'd5 || PC_out !== 32'h100)
            begin errors++; $display("FAIL single_fields got op=%h rd=%0d pc=%h want 33 5 100", opcode_out, destReg_out, PC_out); end
        checks++; if (funct3_out !== 3'd5 || funct7_out !== 7'h20 || srcReg1_out !== 5'd3 || srcReg2_out !== 5'd7 ||
                      lwSw_out !== 2'd2 || {regWrite_out, memRead_out, memWrite_out, memToReg_out, hasImm_out} !== 5'b10101)
            begin errors++; $display("FAIL single_ctrl got f3=%0d f7=%h rs1=%0d rs2=%0d lwsw=%0d ctl=%b", funct3_out, funct7_out,
                                     srcReg1_out, srcReg2_out, lwSw_out, {regWrite_out, memRead_out, memWrite_out, memToReg_out, hasImm_out}); end
        checks++; if (PC_out !== sb[0].pc || imm_out !== sb[0].imm) begin errors++; $display("FAIL single_pop got pc=%h want %h", PC_out, sb[0].pc); end
        drive(0, 7'h00, 5'd0, 32'h0, 1, 0);
        checks++; if (issue_valid !== 1'b0 || count !== 3'd0 || PC_out !== 32'd0)
            begin errors++; $display("FAIL single_drain got iv=%b cnt=%0d pc=%h want 0 0 0", issue_valid, count, PC_out); end
    endtask

    task automatic test_zero_opcode();
        drive(1, 7'h00, 5'd1, 32'h200, 0, 0);
        checks++; if (count !== 3'd0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL zero_op got cnt=%0d drop=%0d want 0 0", count, drop_cnt); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) drive(1, 7'h13, 5'(i + 1), 32'(i * 4), 0, 0);
        checks++; if (count !== 3'd4 || stall !== 1'b1) begin errors++; $display("FAIL full_state got cnt=%0d stall=%b want 4 1", count, stall); end
        drive(1, 7'h13, 5'd9, 32'h40, 0, 0);
        checks++; if (drop_cnt !== 8'd1 || count !== 3'd4) begin errors++; $display("FAIL full_drop got drop=%0d cnt=%0d want 1 4", drop_cnt, count); end
        // Full with a simultaneous pop: pop wins, the push is still refused.
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL full_head got pc=%h want 0", PC_out); end
        drive(1, 7'h13, 5'd9, 32'h44, 1, 0);
        checks++; if (count !== 3'd3 || drop_cnt !== 8'd2 || PC_out !== 32'h4)
            begin errors++; $display("FAIL full_pop got cnt=%0d drop=%0d pc=%h want 3 2 4", count, drop_cnt, PC_out); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 10; i++) begin
            checks++; if (PC_out !== sb[0].pc || destReg_out !== sb[0].rd)
                begin errors++; $display("FAIL stream_order[%0d] got pc=%h want %h", i, PC_out, sb[0].pc); end
            drive(1, 7'h33, 5'(i), 32'(i * 4), 1, 0);
            checks++; if (count !== 3'd3) begin errors++; $display("FAIL stream_count[%0d] got %0d want 3", i, count); end
        end
    endtask

    task automatic test_flush();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d want 3", count); end
        drive(1, 7'h33, 5'd1, 32'h300, 1, 1);
        checks++; if (count !== 3'd0 || issue_valid !== 1'b0 || stall !== 1'b0 || drop_cnt !== 8'(m_drop))
            begin errors++; $display("FAIL flush_state got cnt=%0d iv=%b stall=%b drop=%0d want 0 0 0 %0d", count, issue_valid, stall, drop_cnt, m_drop); end
        drive(1, 7'h23, 5'd2, 32'h304, 0, 0);
        checks++; if (PC_out !== 32'h304 || count !== 3'd1) begin errors++; $display("FAIL flush_after got pc=%h cnt=%0d want 304 1", PC_out, count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bit dv, rdy, fl;
            logic [6:0] op;
            dv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            fl  = ($urandom_range(0, 40) == 0);
            op  = ($urandom_range(0, 9) == 0) ? 7'h00 : 7'($urandom_range(1, 127));
            if (sb.size() != 0 && rdy && !fl) begin
                checks++; if (PC_out !== sb[0].pc || opcode_out !== sb[0].op || imm_out !== sb[0].imm)
                    begin errors++; $display("FAIL rand_head[%0d] got pc=%h op=%h want %h %h", i, PC_out, opcode_out, sb[0].pc, sb[0].op); end
            end
            drive(dv, op, 5'($urandom), $urandom, rdy, fl);
            checks++; if (count !== 3'(sb.size()) || stall !== (sb.size() == DEPTH) || drop_cnt !== 8'(m_drop))
                begin errors++; $display("FAIL rand_state[%0d] got cnt=%0d stall=%b drop=%0d want %0d %0d", i, count, stall, drop_cnt, sb.size(), m_drop); end
        end
    endtask

    task automatic test_saturate();
        while (sb.size() < DEPTH) drive(1, 7'h13, 5'd1, 32'h500 + 32'(sb.size()), 0, 0);
        for (int i = 0; i < 300; i++) drive(1, 7'h13, 5'd1, 32'h600, 0, 0);
        checks++; if (drop_cnt !== 8'd255 || count !== 3'd4) begin errors++; $display("FAIL sat_drop got drop=%0d cnt=%0d want 255 4", drop_cnt, count); end
        test_reset();
        drive(1, 7'h33, 5'd4, 32'h700, 0, 0);
        checks++; if (PC_out !== 32'h700 || count !== 3'd1 || drop_cnt !== 8'd0)
            begin errors++; $display("FAIL sat_after_rst got pc=%h cnt=%0d drop=%0d want 700 1 0", PC_out, count, drop_cnt); end
    endtask

    initial begin
        rst = 1; flush = 0; disp_valid = 0; issue_ready = 0;
        opcode_in = 0; destReg_in = 0; PC_in = 0; imm_in = 0;
        funct3_in = 3'd5; funct7_in = 7'h20; srcReg1_in = 5'd3; srcReg2_in = 5'd7; lwSw_in = 2'd2;
        regWrite_in = 1; memRead_in = 0; memWrite_in = 1; memToReg_in = 0; hasImm_in = 1;
        m_drop = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_zero_opcode();
        test_full();
        test_stream();
        test_flush();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
